// File: rtl/mcs4_rom_loader.sv
// Host-side ROM loader: streams bytes into the i4001 array over the shared debug
// write port while holding the MCS-4 core in reset for the whole session.
module mcs4_rom_loader #(
    parameter int NUM_ROMS = 16,
    parameter int RST_HOLD = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] start_addr,
    input  logic [12:0] byte_count,
    input  logic        abort,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    output logic [11:0] dbg_addr,
    output logic [7:0]  dbg_wdata,
    output logic        dbg_wen,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        LOAD,
        FLUSH,
        RELEASE
    } state_t;

    localparam logic [13:0] LIMIT     = 14'(NUM_ROMS * 256);
    localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD - 1);

    state_t      state;
    logic [15:0] hold_cnt;
    logic [11:0] addr;
    logic [12:0] remaining;
    logic        session;
    logic        aborted;

    logic [13:0] end_addr;
    logic        start_ok;
    logic        hs;
    logic        hold_last;

    // A byte transfers on any rising edge where s_valid and s_ready are both high;
    // s_ready is registered and never depends on s_valid.
    assign end_addr  = {2'b00, start_addr} + {1'b0, byte_count};
    assign start_ok  = (byte_count != 13'd0) && (end_addr <= LIMIT);
    assign hs        = s_valid && s_ready && (state == LOAD);
    assign hold_last = (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RELEASE;
            hold_cnt  <= 16'd0;
            addr      <= 12'd0;
            remaining <= 13'd0;
            session   <= 1'b0;
            aborted   <= 1'b0;
            s_ready   <= 1'b0;
            cpu_rst   <= 1'b1;
            busy      <= 1'b1;
            dbg_wen   <= 1'b0;
            dbg_addr  <= 12'd0;
            dbg_wdata <= 8'd0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done    <= 1'b0;
            err     <= 1'b0;
            // Write pipeline runs in every state so an accepted byte is issued even after abort.
            dbg_wen <= hs;
            if (hs) begin
                dbg_addr  <= addr;
                dbg_wdata <= s_data;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            state     <= HOLD;
                            addr      <= start_addr;
                            remaining <= byte_count;
                            hold_cnt  <= 16'd0;
                            session   <= 1'b1;
                            aborted   <= 1'b0;
                            cpu_rst   <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                HOLD: begin
                    if (abort) begin
                        state    <= RELEASE;
                        hold_cnt <= 16'd0;
                        aborted  <= 1'b1;
                    end else if (hold_last) begin
                        state   <= LOAD;
                        s_ready <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end

                LOAD: begin
                    if (hs) begin
                        addr      <= addr + 12'd1;
                        remaining <= remaining - 13'd1;
                    end
                    if (abort) begin
                        state    <= RELEASE;
                        hold_cnt <= 16'd0;
                        aborted  <= 1'b1;
                        s_ready  <= 1'b0;
                    end else if (hs && (remaining == 13'd1)) begin
                        state   <= FLUSH;
                        s_ready <= 1'b0;
                    end
                end

                FLUSH: begin
                    state    <= RELEASE;
                    hold_cnt <= 16'd0;
                end

                RELEASE: begin
                    if (hold_last) begin
                        state   <= IDLE;
                        cpu_rst <= 1'b0;
                        busy    <= 1'b0;
                        session <= 1'b0;
                        // Reset-initiated releases have no session and report nothing.
                        if (session) begin
                            done <= !aborted;
                            err  <= aborted;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcs4_rom_loader.sv
// Testbench for mcs4_rom_loader: random byte streams checked against a
// linear-address write model through an expected-write queue.
module tb_mcs4_rom_loader;

    localparam int NUM_ROMS = 16;
    localparam int RST_HOLD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] start_addr = 12'd0;
    logic [12:0] byte_count = 13'd0;
    logic        abort = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_ready;
    logic [11:0] dbg_addr;
    logic [7:0]  dbg_wdata;
    logic        dbg_wen;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    mcs4_rom_loader #(.NUM_ROMS(NUM_ROMS), .RST_HOLD(RST_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .byte_count(byte_count), .abort(abort), .s_valid(s_valid),
        .s_ready(s_ready), .s_data(s_data), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_wen(dbg_wen), .cpu_rst(cpu_rst),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [19:0] exp_q[$];
    int          exp_cyc_q[$];
    int wr_cnt = 0, done_cnt = 0, err_cnt = 0, done_cyc = -1, err_cyc = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every issued write must match the oldest expected write.
    initial begin
        logic [19:0] e;
        int          ec;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (dbg_wen) begin
                    wr_cnt++;
                    chk("write_pending", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e  = exp_q.pop_front();
                        ec = exp_cyc_q.pop_front();
                        chk("write_addr_data", {12'd0, dbg_addr, dbg_wdata}, {12'd0, e});
                        chk("write_cycle", cyc, ec);
                        chk("cpu_rst_during_write", {31'd0, cpu_rst}, 32'd1);
                    end
                end
                if (done) begin done_cnt++; done_cyc = cyc; end
                if (err)  begin err_cnt++;  err_cyc  = cyc; end
            end
        end
    end

    task automatic wait_idle(input string name);
        int b = 0;
        while (busy && b < 200) begin @(negedge clk); b++; end
        chk(name, {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    // mode: 0 continuous with bytes idx, 1 toggling valid, 2 random valid.
    task automatic run_load(input logic [11:0] sa, input int n, input int mode,
                            input int abort_at, input int reset_at);
        int idx = 0, t_start, first_rdy = -1, last_hs = -1, wr0, d0, e0, budget = 0, exp_w;
        logic [7:0] b;
        logic v;
        wr0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
        @(negedge clk);
        start = 1'b1; start_addr = sa; byte_count = 13'(n); t_start = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        chk("cpu_rst_after_start", {31'd0, cpu_rst}, 32'd1);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        b = (mode == 0) ? 8'd0 : 8'($urandom);
        while (idx < n && budget < 2000) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (budget % 2 == 0) : 1'($urandom_range(0, 1));
            s_valid = v;
            s_data = b;
            start = (mode == 1 && idx == 3);
            start_addr = (mode == 1 && idx == 3) ? 12'd0 : sa;
            if (s_ready && first_rdy < 0) first_rdy = cyc;
            if (v && s_ready) begin
                exp_q.push_back({sa + 12'(idx), b});
                exp_cyc_q.push_back(cyc + 1);
                last_hs = cyc + 1;
                idx++;
                b = (mode == 0) ? 8'(idx) : 8'($urandom);
                if (idx == abort_at) begin abort = 1'b1; break; end
                if (idx == reset_at) break;
            end
            @(negedge clk);
            budget++;
        end
        chk("first_ready_latency", first_rdy - t_start, RST_HOLD);
        @(negedge clk);
        s_valid = 1'b0; abort = 1'b0; start = 1'b0;
        if (reset_at > 0) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_dbg_wen", {31'd0, dbg_wen}, 32'd0);
            chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
            chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            wait_idle("reset_release_ends");
            chk("rst_write_count", wr_cnt - wr0, reset_at);
            chk("rst_no_done", done_cnt - d0, 0);
            chk("rst_no_err", err_cnt - e0, 0);
        end else begin
            chk("s_ready_after_last", {31'd0, s_ready}, 32'd0);
            wait_idle("session_ends");
            exp_w = (abort_at > 0) ? abort_at : n;
            chk("write_count", wr_cnt - wr0, exp_w);
            if (abort_at > 0) begin
                chk("abort_err_pulses", err_cnt - e0, 1);
                chk("abort_done_pulses", done_cnt - d0, 0);
                chk("abort_err_timing", err_cyc - last_hs, RST_HOLD);
            end else begin
                chk("done_pulses", done_cnt - d0, 1);
                chk("err_pulses", err_cnt - e0, 0);
                chk("done_timing", done_cyc - last_hs, RST_HOLD + 1);
            end
            chk("cpu_rst_idle", {31'd0, cpu_rst}, 32'd0);
        end
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic run_reject(input logic [11:0] sa, input int n);
        int t, wr0, d0, e0;
        wr0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
        @(negedge clk);
        start = 1'b1; start_addr = sa; byte_count = 13'(n); t = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        chk("reject_busy", {31'd0, busy}, 32'd0);
        chk("reject_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        repeat (3) @(negedge clk);
        chk("reject_err_pulses", err_cnt - e0, 1);
        chk("reject_err_timing", err_cyc, t);
        chk("reject_done", done_cnt - d0, 0);
        chk("reject_writes", wr_cnt - wr0, 0);
    endtask

    initial begin
        int cnt, a, e0, wr0, n;
        repeat (3) @(negedge clk);
        chk("reset_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd1);
        chk("reset_s_ready", {31'd0, s_ready}, 32'd0);
        chk("reset_dbg", {11'd0, dbg_wen, dbg_addr, dbg_wdata}, 32'd0);
        chk("reset_pulses", {30'd0, done, err}, 32'd0);
        rst_n = 1'b1;
        cnt = 0;
        while (cpu_rst === 1'b1 && cnt < 100) begin cnt++; @(negedge clk); end
        chk("reset_hold_cycles", cnt, RST_HOLD);
        chk("reset_busy_falls", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("reset_no_done", done_cnt, 0);
        chk("reset_no_err", err_cnt, 0);

        // Abort in IDLE does nothing.
        e0 = err_cnt;
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_abort_ignored", err_cnt - e0, 0);

        run_load(12'h1F0, 32, 0, 0, 0);
        run_load(12'h1F0, 32, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            n = $urandom_range(1, 40);
            run_load(12'($urandom_range(0, 4096 - n)), n, 2, 0, 0);
        end
        run_load(12'hFFF, 1, 2, 0, 0);
        run_reject(12'hFFF, 2);
        run_reject(12'h1FF, 0);
        run_reject(12'hF80, 200);
        run_load(12'h3A0, 10, 0, 5, 0);

        // Abort during HOLD: no bytes, err after the release hold.
        e0 = err_cnt; wr0 = wr_cnt;
        @(negedge clk); start = 1'b1; start_addr = 12'h040; byte_count = 13'd8;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1; a = cyc + 1;
        @(negedge clk); abort = 1'b0;
        wait_idle("hold_abort_ends");
        chk("hold_abort_err", err_cnt - e0, 1);
        chk("hold_abort_err_timing", err_cyc - a, RST_HOLD);
        chk("hold_abort_writes", wr_cnt - wr0, 0);

        run_load(12'h100, 20, 0, 0, 6);
        run_load(12'h500, 8, 2, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
